// File: rtl/sub_slt_pkg.sv
// Shared types for the SUB/SLT scheduler: op codes, FSM states and the SLT decision.
package sub_slt_pkg;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_SLT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // With fix_en the sign bit is corrected for signed overflow of the subtraction.
  function automatic logic slt_lt(input logic diff_msb, input logic a_msb,
                                  input logic b_msb, input logic fix_en);
    logic ovf;
    ovf = (a_msb != b_msb) && (diff_msb != a_msb);
    if (fix_en) begin
      return diff_msb ^ ovf;
    end else begin
      return diff_msb;
    end
  endfunction

endpackage

// File: rtl/sub_slt_scheduler_arbiter.sv
// Combinational round-robin grant: first valid requester at or after rr_ptr (wrapping).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W:0] pos;

  // Rotating priority search; the one extra bit of pos absorbs the wrap.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    pos         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end else begin
        pos = pos;
      end
      if (!grant_valid && req_valid[pos[IDX_W-1:0]]) begin
        grant_valid              = 1'b1;
        grant_idx                = pos[IDX_W-1:0];
        grant[pos[IDX_W-1:0]]    = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/sub_slt_scheduler.sv
// Round-robin scheduler sharing one subtractor (SUB / signed SLT) among NUM_REQ requesters.
// Build option: define SLT_OVF_FIX_EN for overflow-corrected signed SLT.
module sub_slt_scheduler
  import sub_slt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
`ifdef SLT_OVF_FIX_EN
  localparam logic SLT_FIX = 1'b1;
`else
  localparam logic SLT_FIX = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               op_q, op_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               grant_valid_s;
  logic               accept_s;
  logic [WIDTH-1:0]   diff_s;
  logic               lt_s;
  logic [WIDTH-1:0]   result_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // The single shared subtractor; SLT reuses its difference.
  assign diff_s   = a_q - b_q;
  assign lt_s     = slt_lt(diff_s[WIDTH-1], a_q[WIDTH-1], b_q[WIDTH-1], SLT_FIX);
  assign result_s = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, lt_s} : diff_s;
  assign accept_s = |(req_valid & req_ready);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_SUB;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, response capture in EXEC, release on response handshake.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d  = req_a[grant_idx_s*WIDTH +: WIDTH];
          b_d  = req_b[grant_idx_s*WIDTH +: WIDTH];
          op_d = req_op[grant_idx_s];
          id_d = grant_idx_s;
          if (grant_idx_s == IDX_W'(NUM_REQ-1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx_s + IDX_W'(1);
          end
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      S_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = result_s;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: rsp_valid_d = 1'b0;
    endcase
  end

  // Outputs; req_ready is masked while reset is asserted so nothing is accepted then.
  always_comb begin
    if ((state_q == S_IDLE) && !reset && grant_valid_s) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
    busy      = (state_q != S_IDLE);
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_data  = rsp_data_q;
  end

endmodule

// File: tb/tb_sub_slt_scheduler.sv
// Directed + randomized bench for sub_slt_scheduler against a behavioural reference model.
module tb_sub_slt_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  sub_slt_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first valid index scanning ptr, ptr+1, ... modulo N.
  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_result(input logic op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    if (op == 1'b0) return d;
`ifdef SLT_OVF_FIX_EN
    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`else
    return {31'd0, d[31]};
`endif
  endfunction

  task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
    req_op[i]      = op;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ptr = 0;
  endtask

  // One transaction from the IDLE cycle through the return to IDLE; rsp_ready low for `stall` RESP cycles.
  task automatic run_txn(input logic [N-1:0] vmask, input int stall);
    int          g;
    logic [3:0]  oh;
    logic [31:0] exp_d;
    g = model_grant(vmask, m_ptr);
    oh = 4'b0001;
    oh = oh << g;
    req_valid = vmask;
    #1;
    chk("grant_ready", {28'd0, req_ready}, {28'd0, oh});
    exp_d = model_result(req_op[g], req_a[g*W +: W], req_b[g*W +: W]);
    @(posedge clk); #1;
    m_ptr = (g + 1) % N;
    chk("exec_busy", {31'd0, busy}, 32'd1);
    chk("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("exec_req_ready", {28'd0, req_ready}, 32'd0);
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("resp_data", rsp_data, exp_d);
    chk("resp_id", {30'd0, rsp_id}, g);
    for (int s = 1; s <= stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, exp_d);
      chk("stall_id", {30'd0, rsp_id}, g);
      chk("stall_req_ready", {28'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    do_reset();

    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Basic SUB on requester 0.
    set_req(0, 1'b0, 32'd10, 32'd3);
    run_txn(4'b0001, 0);
    chk("sub_10_3", rsp_data, 32'd7);

    // Signed SLT on requester 2.
    set_req(2, 1'b1, 32'hFFFF_FFFF, 32'd1);
    run_txn(4'b0100, 0);
    chk("slt_m1_1", rsp_data, 32'd1);
    set_req(2, 1'b1, 32'd5, 32'hFFFF_FFFE);
    run_txn(4'b0100, 0);
    chk("slt_5_m2", rsp_data, 32'd0);

    // Overflowing SLT: answer depends on the build option.
    set_req(2, 1'b1, 32'h8000_0000, 32'd1);
    run_txn(4'b0100, 0);
`ifdef SLT_OVF_FIX_EN
    chk("slt_ovf", rsp_data, 32'd1);
`else
    chk("slt_ovf", rsp_data, 32'd0);
`endif

    // All requesters busy: ids 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'd100 + i, 32'd1);
    for (int k = 0; k < 6; k++) begin
      run_txn(4'b1111, 0);
      chk("rr_seq_id", {30'd0, rsp_id}, k % N);
    end

    // Response back-pressure for five cycles.
    set_req(3, 1'b0, 32'd0, 32'd1);
    run_txn(4'b1000, 5);
    chk("stall_result", rsp_data, 32'hFFFF_FFFF);
    req_valid = '0;

    // Reset during EXEC: moves rr_ptr to 2 first, then checks it returns to 0.
    set_req(1, 1'b0, 32'd50, 32'd8);
    set_req(3, 1'b0, 32'd70, 32'd9);
    run_txn(4'b0010, 0);
    req_valid = 4'b0010;
    #1;
    chk("mid_grant", {28'd0, req_ready}, 32'd2);
    @(posedge clk); #1;
    chk("mid_exec_busy", {31'd0, busy}, 32'd1);
    reset     = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ptr = 0;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    chk("mid_after_valid", {31'd0, rsp_valid}, 32'd0);
    run_txn(4'b1010, 0);
    chk("mid_first_id", {30'd0, rsp_id}, 32'd1);
    req_valid = '0;

    // Randomized traffic with random masks, operands and back-pressure.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), pick_operand(), pick_operand());
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
